fm_range_sequencer: RTL

//  Cycle sequencer and auto-range controller for the decade-counter frequency meter datapath.

---
 rtl/fm_range_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fm_range_sequencer.sv
// Measurement cycle sequencer and auto-range controller for the decade-counter frequency meter.
// Each cycle runs clear -> gate -> settle -> evaluate; evaluation either retries on another range or latches.
module fm_range_sequencer #(
    parameter int N_RANGES   = 3,
    parameter int GATE_MAX   = 1000,
    parameter int RATIO      = 10,
    parameter int SETTLE     = 2,
    parameter int MAX_RETRY  = 4,
    parameter int INIT_RANGE = 0
) (
    input  logic                                              i_clk,
    input  logic                                              i_clr,
    input  logic                                              i_run,
    input  logic                                              i_ovf,
    input  logic                                              i_udf,
    output logic                                              o_gate,
    output logic                                              o_cnt_clr,
    output logic                                              o_latch,
    output logic                                              o_done,
    output logic [((N_RANGES > 1) ? $clog2(N_RANGES) : 1)-1:0] o_range,
    output logic                                              o_range_chg,
    output logic                                              o_q_ovf,
    output logic                                              o_range_err,
    output logic                                              o_busy,
    output logic [2:0]                                        o_state
);

    localparam int RW   = (N_RANGES > 1) ? $clog2(N_RANGES) : 1;
    localparam int CW_G = $clog2(GATE_MAX + 1);
    localparam int CW_S = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int CW   = (CW_G > CW_S) ? CW_G : CW_S;
    localparam int TW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TABN = 1 << RW;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GATE  = 3'd2,
        S_WAIT  = 3'd3,
        S_EVAL  = 3'd4,
        S_LATCH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_range;
    logic [TW-1:0]   r_retry;
    logic            r_range_chg;
    logic            r_forced;
    logic            r_q_ovf;
    logic            r_range_err;
    logic            w_force;
    logic            w_up;
    logic            w_dn;
    logic [CW-1:0]   w_gate_tab [TABN];

    // Gate length table G(r) = GATE_MAX / RATIO^r; unused encodings get a harmless 1.
    genvar g;
    generate
        for (g = 0; g < TABN; g++) begin : g_tab
            localparam int GV = (g < N_RANGES) ? GATE_MAX / (RATIO ** g) : 1;
            assign w_gate_tab[g] = CW'(GV);
        end
    endgenerate

    // Evaluation decisions; rule order is force, then overflow, then underflow.
    assign w_force = (r_retry == TW'(MAX_RETRY));
    assign w_up    = i_ovf && (r_range < RW'(N_RANGES - 1));
    assign w_dn    = !i_ovf && i_udf && (r_range != '0);

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_run) w_next = S_CLEAR;
            S_CLEAR: w_next = S_GATE;
            S_GATE: begin
                if (r_cnt == '0) w_next = (SETTLE == 0) ? S_EVAL : S_WAIT;
            end
            S_WAIT:  if (r_cnt == '0) w_next = S_EVAL;
            S_EVAL: begin
                if (w_force)           w_next = S_LATCH;
                else if (w_up || w_dn) w_next = S_CLEAR;
                else                   w_next = S_LATCH;
            end
            S_LATCH: w_next = S_DONE;
            S_DONE:  w_next = i_run ? S_CLEAR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cnt       <= '0;
            r_range     <= RW'(INIT_RANGE);
            r_retry     <= '0;
            r_range_chg <= 1'b0;
            r_forced    <= 1'b0;
            r_q_ovf     <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_range_chg <= 1'b0;
            case (r_state)
                S_CLEAR: r_cnt <= w_gate_tab[r_range] - 1'b1;
                S_GATE: begin
                    if (r_cnt == '0) r_cnt <= SETTLE_LOAD;
                    else             r_cnt <= r_cnt - 1'b1;
                end
                S_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_EVAL: begin
                    if (w_force) begin
                        r_range_err <= 1'b1;
                        r_forced    <= 1'b1;
                    end else if (w_up) begin
                        r_range     <= r_range + 1'b1;
                        r_range_chg <= 1'b1;
                        r_retry     <= r_retry + 1'b1;
                        r_forced    <= 1'b0;
                    end else if (w_dn) begin
                        r_range     <= r_range - 1'b1;
                        r_range_chg <= 1'b1;
                        r_retry     <= r_retry + 1'b1;
                        r_forced    <= 1'b0;
                    end else begin
                        r_forced    <= 1'b0;
                    end
                end
                S_LATCH: begin
                    r_q_ovf     <= i_ovf;
                    r_range_err <= r_forced;
                    r_retry     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an async clear drops them at once.
    assign o_gate      = (r_state == S_GATE);
    assign o_cnt_clr   = (r_state == S_CLEAR);
    assign o_latch     = (r_state == S_LATCH);
    assign o_done      = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_range     = r_range;
    assign o_range_chg = r_range_chg;
    assign o_q_ovf     = r_q_ovf;
    assign o_range_err = r_range_err;
    assign o_state     = r_state;

endmodule
